// File: rtl/instr_decode_queue.sv
// Instruction decode queue: a circular FIFO of fetched {pc, instr} pairs between
// fetch and decode. The head entry is presented already split into MIPS fields.
module instr_decode_queue #(
    parameter int INSTR_W   = 32,
    parameter int PC_W      = 32,
    parameter int DEPTH     = 4,
    parameter int IMM_EXT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [5:0]               out_opcode,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_shamt,
    output logic [5:0]               out_funct,
    output logic [IMM_EXT_W-1:0]     out_simm,
    output logic [IMM_EXT_W-1:0]     out_zimm,
    output logic [25:0]              out_jaddr,
    output logic [1:0]               out_fmt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;

    // Ready/valid come only from registered occupancy, so there is no
    // combinational path from out_ready to in_ready. Flush cancels both
    // transfers so the instruction offered in a flush cycle is never accepted.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Storage array: written only on an accepted push; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry is masked to zero when empty so every field output reads 0.
    assign head_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign head_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

    assign out_instr  = head_instr;
    assign out_pc     = head_pc;
    assign out_opcode = head_instr[31:26];
    assign out_rs     = head_instr[25:21];
    assign out_rt     = head_instr[20:16];
    assign out_rd     = head_instr[15:11];
    assign out_shamt  = head_instr[10:6];
    assign out_funct  = head_instr[5:0];
    assign out_jaddr  = head_instr[25:0];
    assign out_simm   = IMM_EXT_W'($signed(head_instr[15:0]));
    assign out_zimm   = IMM_EXT_W'(head_instr[15:0]);

    // Format class from opcode: R for 0, J for 2/3, I otherwise; 0 when empty.
    always_comb begin
        out_fmt = 2'b00;
        if (out_valid) begin
            case (head_instr[31:26])
                6'd0:       out_fmt = 2'b00;
                6'd2, 6'd3: out_fmt = 2'b10;
                default:    out_fmt = 2'b01;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed testbench for instr_decode_queue (DEPTH = 4).
module tb_instr_decode_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [31:0] out_simm;
    logic [31:0] out_zimm;
    logic [25:0] out_jaddr;
    logic [1:0]  out_fmt;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    instr_decode_queue #(
        .INSTR_W(32), .PC_W(32), .DEPTH(4), .IMM_EXT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_simm(out_simm),
        .out_zimm(out_zimm), .out_jaddr(out_jaddr), .out_fmt(out_fmt), .count(count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs driven from the preceding falling edge;
    // returns 1 unit after the rising edge so outputs can be sampled.
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_outputs: instr %h pc %h expected 0", out_instr, out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        step(1'b1, 32'h014B4820, 32'h00400000, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL r_valid: got %0b expected 1", out_valid); end
        checks++; if (out_opcode !== 6'd0) begin errors++; $display("[TB] FAIL r_opcode: got %h expected 00", out_opcode); end
        checks++; if (out_rs !== 5'd10 || out_rt !== 5'd11 || out_rd !== 5'd9) begin errors++; $display("[TB] FAIL r_regs: got rs %0d rt %0d rd %0d expected 10 11 9", out_rs, out_rt, out_rd); end
        checks++; if (out_shamt !== 5'd0 || out_funct !== 6'h20) begin errors++; $display("[TB] FAIL r_shamt_funct: got %0d %h expected 0 20", out_shamt, out_funct); end
        checks++; if (out_fmt !== 2'b00) begin errors++; $display("[TB] FAIL r_fmt: got %b expected 00", out_fmt); end
        checks++; if (out_pc !== 32'h00400000) begin errors++; $display("[TB] FAIL r_pc: got %h expected 00400000", out_pc); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_funct !== 6'h0) begin errors++; $display("[TB] FAIL r_pop_empty: valid %0b instr %h funct %h expected 0", out_valid, out_instr, out_funct); end
    endtask

    task automatic test_itype();
        step(1'b1, 32'h2128FFFC, 32'h00400004, 1'b0, 1'b0);
        checks++; if (out_opcode !== 6'h08 || out_rs !== 5'd9 || out_rt !== 5'd8) begin errors++; $display("[TB] FAIL i_fields: got op %h rs %0d rt %0d expected 08 9 8", out_opcode, out_rs, out_rt); end
        checks++; if (out_simm !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL i_simm: got %h expected FFFFFFFC", out_simm); end
        checks++; if (out_zimm !== 32'h0000FFFC) begin errors++; $display("[TB] FAIL i_zimm: got %h expected 0000FFFC", out_zimm); end
        checks++; if (out_fmt !== 2'b01) begin errors++; $display("[TB] FAIL i_fmt: got %b expected 01", out_fmt); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_jtype();
        step(1'b1, 32'h08040000, 32'h00400008, 1'b0, 1'b0);
        step(1'b1, 32'h0C000010, 32'h0040000C, 1'b0, 1'b0);
        checks++; if (out_opcode !== 6'd2 || out_jaddr !== 26'h0040000 || out_fmt !== 2'b10) begin errors++; $display("[TB] FAIL j_first: got op %h jaddr %h fmt %b expected 02 0040000 10", out_opcode, out_jaddr, out_fmt); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_opcode !== 6'd3 || out_fmt !== 2'b10 || out_jaddr !== 26'h0000010) begin errors++; $display("[TB] FAIL jal_fields: got op %h fmt %b jaddr %h expected 03 10 0000010", out_opcode, out_fmt, out_jaddr); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL j_drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_full_backpressure();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hA000_0000 + i, 32'h1000 + 4 * i, 1'b0, 1'b0);
        end
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_state: count %0d in_ready %0b expected 4 0", count, in_ready); end
        // Fifth instruction offered while full and stalled: must be held off.
        step(1'b1, 32'hA000_0004, 32'h1010, 1'b0, 1'b0);
        checks++; if (count !== 3'd4 || out_instr !== 32'hA000_0000) begin errors++; $display("[TB] FAIL full_hold: count %0d head %h expected 4 A0000000", count, out_instr); end
        // Pop while full: fifth still not accepted (ready is registered-state based).
        step(1'b1, 32'hA000_0004, 32'h1010, 1'b1, 1'b0);
        checks++; if (count !== 3'd3 || out_instr !== 32'hA000_0001) begin errors++; $display("[TB] FAIL full_pop1: count %0d head %h expected 3 A0000001", count, out_instr); end
        // Now count is 3: fifth accepted alongside a pop.
        step(1'b1, 32'hA000_0004, 32'h1010, 1'b1, 1'b0);
        checks++; if (count !== 3'd3 || out_instr !== 32'hA000_0002) begin errors++; $display("[TB] FAIL full_pop2: count %0d head %h expected 3 A0000002", count, out_instr); end
        for (int i = 3; i < 5; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++; if (out_instr !== 32'hA000_0000 + i || out_pc !== 32'h1000 + 4 * i) begin errors++; $display("[TB] FAIL full_order%0d: head %h pc %h expected %h %h", i, out_instr, out_pc, 32'hA000_0000 + i, 32'h1000 + 4 * i); end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drain: count %0d valid %0b expected 0 0", count, out_valid); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'hB000_0000, 32'h2000, 1'b1, 1'b0);
        checks++; if (count !== 3'd1 || out_instr !== 32'hB000_0000) begin errors++; $display("[TB] FAIL b2b_first: count %0d head %h expected 1 B0000000", count, out_instr); end
        for (int i = 1; i < 10; i++) begin
            step(1'b1, 32'hB000_0000 + i, 32'h2000 + 4 * i, 1'b1, 1'b0);
            checks++; if (count !== 3'd1 || out_instr !== 32'hB000_0000 + i) begin errors++; $display("[TB] FAIL b2b_%0d: count %0d head %h expected 1 %h", i, count, out_instr, 32'hB000_0000 + i); end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL b2b_drain: count %0d expected 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hC000_0000 + i, 32'h3000 + 4 * i, 1'b0, 1'b0);
        end
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre: count %0d expected 3", count); end
        step(1'b1, 32'hDEADBEEF, 32'h0000DEAD, 1'b1, 1'b1);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_state: count %0d valid %0b ready %0b expected 0 0 1", count, out_valid, in_ready); end
        checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_simm !== 32'h0 || out_fmt !== 2'b00) begin errors++; $display("[TB] FAIL flush_outputs: instr %h pc %h simm %h fmt %b expected 0", out_instr, out_pc, out_simm, out_fmt); end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_ghost: valid %0b instr %h expected 0", out_valid, out_instr); end
        step(1'b1, 32'h2128FFFC, 32'h00500000, 1'b0, 1'b0);
        checks++; if (out_instr !== 32'h2128FFFC || out_pc !== 32'h00500000 || count !== 3'd1) begin errors++; $display("[TB] FAIL flush_refill: head %h pc %h count %0d expected 2128FFFC 00500000 1", out_instr, out_pc, count); end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'hE000_0000, 32'h4000, 1'b0, 1'b0);
        step(1'b1, 32'hE000_0001, 32'h4004, 1'b0, 1'b0);
        checks++; if (count !== 3'd2 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre: count %0d valid %0b expected 2 1", count, out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_immediate: valid %0b count %0d ready %0b expected 0 0 1", out_valid, count, in_ready); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL areset_instr: got %h expected 0", out_instr); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h014B4820, 32'h00400000, 1'b0, 1'b0);
        checks++; if (out_instr !== 32'h014B4820 || count !== 3'd1) begin errors++; $display("[TB] FAIL areset_after: head %h count %0d expected 014B4820 1", out_instr, count); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_jtype();
        test_full_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised, buffered successor to the combinational instruction field splitters.
- Sits between fetch and decode. Holds up to DEPTH fetched instructions with their PCs in a circular FIFO.
- Presents the head entry to decode already split into fields: opcode, rs, rt, rd, shamt, funct, sign/zero-extended immediate, jump target field and format class.
- Uses a valid/ready handshake on both sides and supports a synchronous flush for branch/jump redirects.

Parameters:
- INSTR_W, 32, instruction width; fixed MIPS field positions, so only 32 is legal.
- PC_W, 32, width of the PC carried alongside each instruction.
- DEPTH, 4, number of queue entries; power of 2, at least 2.
- IMM_EXT_W, 32, width of the extended-immediate outputs; at least 16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  PC_W  PC of the head entry.
- out_instr  out  INSTR_W  raw head instruction.
- out_opcode  out  6  head bits [31:26].
- out_rs  out  5  head bits [25:21].
- out_rt  out  5  head bits [20:16].
- out_rd  out  5  head bits [15:11].
- out_shamt  out  5  head bits [10:6].
- out_funct  out  6  head bits [5:0].
- out_simm  out  IMM_EXT_W  bits [15:0] sign-extended.
- out_zimm  out  IMM_EXT_W  bits [15:0] zero-extended.
- out_jaddr  out  26  head bits [25:0], unprocessed.
- out_fmt  out  2  format class: 00 R (opcode 0), 10 J (opcode 2 or 3), 01 I (all others); 11 never driven.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; every storage entry clears to 0.
  - out_valid = 0, in_ready = 1, all field outputs = 0.
  - Reset asserted mid-stream drops all entries immediately.
  - Release is synchronous to clk; the first push is accepted on the first rising edge after release.
- **Push**: push = in_valid && in_ready, where in_ready = (count != DEPTH). On push, {in_pc, in_instr} is written at wr_ptr and wr_ptr increments modulo DEPTH (natural wrap).
- **Pop**: pop = out_valid && out_ready, where out_valid = (count != 0). On pop, rd_ptr increments modulo DEPTH.
- **Occupancy update**:
  - count +1 on push only; −1 on pop only; unchanged on simultaneous push and pop.
  - Simultaneous push and pop is legal at any occupancy from 1 to DEPTH−1.
  - When full, in_ready = 0, so there is no push, even if a pop happens in the same cycle (no combinational ready path).
  - When empty, there is no pop; an incoming instruction never bypasses storage.
- **Latency**: an instruction pushed at edge N appears on the outputs with out_valid = 1 after edge N if the queue was empty.
  - Minimum in-to-out latency is 1 cycle.
  - Throughput is 1 instruction per cycle in steady state.
- **Field outputs**:
  - All are combinational decodes of the registered head entry. No extra pipeline stage.
  - When out_valid = 0, all field outputs, out_pc and out_instr are forced to 0.
  - Outputs hold stable while out_valid && !out_ready; the head must not change under a stall.
- **Flush**: on a clock edge with flush = 1:
  - wr_ptr, rd_ptr and count go to 0; stored data may remain.
  - Flush overrides push and pop in the same cycle: the in_instr offered that cycle is discarded and does not count as accepted.
  - The cycle after a flush, out_valid = 0 and in_ready = 1.
- **Ordering**: strict FIFO. No entry is dropped except by flush or reset.
- **Pointer width**: pointers are clog2(DEPTH) bits. count has one extra bit so that full (count = DEPTH) is distinguishable from empty.

Test Plan:
- **Reset and R-type decode**: reset, then push 0x014B4820 (add $t1,$t2,$t3) with pc 0x00400000 → next cycle out_valid = 1, opcode 0, rs 10, rt 11, rd 9, shamt 0, funct 0x20, fmt 00, out_pc 0x00400000.
- **I-type extension**: push 0x2128FFFC (addi) → opcode 0x08, rs 9, rt 8, simm 0xFFFFFFFC, zimm 0x0000FFFC, fmt 01.
- **J-type**: push 0x08040000 → opcode 2, jaddr 0x0040000, fmt 10. Push 0x0C000010 → opcode 3, fmt 10.
- **Full/backpressure, DEPTH = 4**: hold out_ready = 0 and push 5 instructions →
  - count 4 and in_ready = 0 after the 4th push; the 5th is held.
  - Raise out_ready → the 4 entries pop in order; the 5th is accepted when count drops to 3 (in_ready is registered-state based).
  - Wrap-around: run 10 instructions back-to-back with out_ready = 1 and concurrent push/pop → order preserved, count stays at 1.
- **Flush**: with 3 entries queued, assert flush together with in_valid = 1 → next cycle count 0, out_valid 0, outputs 0. The flushed cycle's instruction never appears on the outputs.
- **Async reset mid-operation**: drop rst_n between clock edges with 2 entries queued → out_valid falls immediately and count = 0 without waiting for a clock edge.
